// File: rtl/lfsr_checker_if.sv
// Serial bit-stream bus between a stimulus/monitor side and lfsr_checker.
// master drives the stream and clear; slave (the checker) reports status.
interface lfsr_checker_if;
  logic        enable;
  logic        data_in;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output enable,
    output data_in,
    output clear,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  bit_count
  );

  modport slave (
    input  enable,
    input  data_in,
    input  clear,
    output locked,
    output err_pulse,
    output err_count,
    output bit_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Checker for the x^8+x^6+x^5+x^4+1 LFSR stream: search/lock FSM, error stats.
// Define LFSR_CHECKER_BITCNT_EN to build the checked-bit counter.
module lfsr_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int WIN_LEN    = 64,
  parameter int ERR_THRESH = 8
) (
  input logic          clk,
  input logic          reset,
  lfsr_checker_if.slave bus
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] WIN_LAST  = 8'(WIN_LEN - 1);
  localparam logic [7:0] ERR_LIM   = 8'(ERR_THRESH);

  logic [0:0]  state;
  logic [7:0]  hist;
  logic [7:0]  lfsr;
  logic [3:0]  fill;
  logic [7:0]  match_cnt;
  logic [7:0]  win_pos;
  logic [7:0]  win_err;
  logic        err_pulse;
  logic [15:0] err_count;

  logic        hist_pred;
  logic        lfsr_pred;
  logic        in_lock;
  logic        search;
  logic        filled;
  logic        check;
  logic        err;
  logic        hit;
  logic        acquire;
  logic        lose;
  logic        win_wrap;
  logic [7:0]  win_err_nxt;

  // Predictions, match/error qualification and lock transitions.
  always_comb begin
    hist_pred   = hist[7] ^ hist[5] ^ hist[4] ^ hist[3];
    lfsr_pred   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    in_lock     = (state == LOCKED);
    filled      = (fill == 4'd8);
    search      = bus.enable & ~in_lock;
    check       = bus.enable & in_lock;
    err         = check & (bus.data_in != lfsr_pred);
    hit         = search & filled
                & (bus.data_in == hist_pred)
                & (hist != 8'h00);
    acquire     = hit & (match_cnt == LOCK_LAST);
    win_err_nxt = win_err + 8'(err);
    lose        = check & (win_err_nxt == ERR_LIM);
    win_wrap    = (win_pos == WIN_LAST);
  end

  // Lock state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      case (state)
        SEARCH:  if (acquire) state <= LOCKED;
        LOCKED:  if (lose)    state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end

  // Shift history of received bits, newest in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 8'h00;
    end else if (bus.enable) begin
      hist <= {hist[6:0], bus.data_in};
    end
  end

  // Fill count: first 8 bits after (re)entering search carry no prediction.
  always_ff @(posedge clk) begin
    if (reset || lose) begin
      fill <= 4'd0;
    end else if (search && !filled) begin
      fill <= fill + 4'd1;
    end
  end

  // Consecutive correct predictions while searching.
  always_ff @(posedge clk) begin
    if (reset || lose || acquire) begin
      match_cnt <= 8'd0;
    end else if (search && filled) begin
      match_cnt <= hit ? match_cnt + 8'd1 : 8'd0;
    end
  end

  // Free-running local generator; seeded from the stream only at lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 8'h00;
    end else if (acquire) begin
      lfsr <= {hist[6:0], bus.data_in};
    end else if (check) begin
      lfsr <= {lfsr[6:0], lfsr_pred};
    end
  end

  // Error window; the threshold test sees the window's final bit first.
  always_ff @(posedge clk) begin
    if (reset || lose) begin
      win_pos <= 8'd0;
      win_err <= 8'd0;
    end else if (check) begin
      if (win_wrap) begin
        win_pos <= 8'd0;
        win_err <= 8'd0;
      end else begin
        win_pos <= win_pos + 8'd1;
        win_err <= win_err_nxt;
      end
    end
  end

  // One-cycle error strobe, low whenever no bit is checked.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err;
    end
  end

  // Saturating error total; an error on the clear cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 16'h0000;
    end else if (bus.clear) begin
      err_count <= {15'd0, err};
    end else if (err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

`ifdef LFSR_CHECKER_BITCNT_EN
  logic [31:0] bit_count;

  // Wrapping count of bits checked while locked.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= 32'd0;
    end else if (bus.clear) begin
      bit_count <= {31'd0, check};
    end else if (check) begin
      bit_count <= bit_count + 32'd1;
    end
  end

  assign bus.bit_count = bit_count;
`else
  assign bus.bit_count = 32'd0;
`endif

  assign bus.locked    = in_lock;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;

endmodule
